// File: rtl/counter_pkg.sv
// Shared display types and the hex to seven-segment lookup used by updown_counter_seg.
package counter_pkg;

    typedef logic [0:6] seg_t;  // segments a..g, active-low

    localparam seg_t SEG_BLANK = 7'b1111111;

    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        seg_t s;
        case (hex)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed hex display driver: one digit lit per scan slot, seg/an registered.
// SEG_LEADING_ZERO_BLANK_EN blanks digits above the most-significant non-zero nibble.
module seg_scan
    import counter_pkg::*;
#(
    parameter int SCAN_DIV   = 100_000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    output seg_t                    seg,
    output logic [0:NUM_DIGITS-1]   an
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         idx;
    logic                  scan_end;
    logic [3:0]            nibble;
    logic                  show;
    logic [0:NUM_DIGITS-1] an_next;

    assign scan_end = (scan_cnt == SW'(SCAN_DIV - 1));
    assign nibble   = value[4*int'(idx) +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [IW-1:0] msd;

    // Digit 0 stays lit even for an all-zero value, so msd defaults to 0.
    always_comb begin
        msd = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (value[4*d +: 4] != 4'h0) msd = IW'(d);
        end
        show = (idx <= msd);
    end
`else
    assign show = 1'b1;
`endif

    always_comb begin
        an_next = '1;
        if (show) an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= SEG_BLANK;
            an       <= '1;
        end else begin
            scan_cnt <= scan_end ? '0 : scan_cnt + SW'(1);
            if (scan_end) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
            seg <= show ? hex_to_seg(nibble) : SEG_BLANK;
            an  <= an_next;
        end
    end

endmodule

// File: rtl/updown_counter_seg.sv
// Up/down counter with prescaled step, synchronous load, wrap pulse, LED and hex display.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (leading-zero blanking in seg_scan).
module updown_counter_seg
    import counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int TICK_DIV   = 100_000_000,
    parameter int SCAN_DIV   = 100_000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_up,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_load_value,
    output logic [WIDTH-1:0]      o_count,
    output logic                  o_wrap,
    output logic                  o_led,
    output seg_t                  seg,
    output logic [0:NUM_DIGITS-1] an,
    output logic                  dp
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]           pre;
    logic                    tick;
    logic [4*NUM_DIGITS-1:0] disp_value;

    assign tick = (pre == PW'(TICK_DIV - 1)) & i_enable;

    // Load beats a coincident tick and restarts the prescale interval.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_count <= '0;
            pre     <= '0;
            o_wrap  <= 1'b0;
        end else begin
            o_wrap <= 1'b0;
            if (i_load) begin
                o_count <= i_load_value;
                pre     <= '0;
            end else begin
                if (i_enable) pre <= tick ? '0 : pre + PW'(1);
                if (tick) begin
                    if (i_up) begin
                        o_count <= o_count + WIDTH'(1);
                        o_wrap  <= (o_count == '1);
                    end else begin
                        o_count <= o_count - WIDTH'(1);
                        o_wrap  <= (o_count == '0);
                    end
                end
            end
        end
    end

    assign o_led      = o_count[WIDTH-1];
    assign dp         = 1'b1;
    assign disp_value = (4*NUM_DIGITS)'(o_count);

    seg_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_seg_scan (
        .clk     (clk),
        .i_reset (i_reset),
        .value   (disp_value),
        .seg     (seg),
        .an      (an)
    );

endmodule

// File: tb/tb_updown_counter_seg.sv
// Directed bench for updown_counter_seg: driver pushes expectations, negedge monitor checks them.
module tb_updown_counter_seg;
    import counter_pkg::*;

    localparam int WIDTH      = 8;
    localparam int TICK_DIV   = 4;
    localparam int SCAN_DIV   = 2;
    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] K_COUNT = 4'd0;
    localparam logic [3:0] K_WRAP  = 4'd1;
    localparam logic [3:0] K_LED   = 4'd2;
    localparam logic [3:0] K_SEG   = 4'd3;
    localparam logic [3:0] K_AN    = 4'd4;
    localparam logic [3:0] K_DP    = 4'd5;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  i_reset;
    logic                  i_enable;
    logic                  i_up;
    logic                  i_load;
    logic [WIDTH-1:0]      i_load_value;
    logic [WIDTH-1:0]      o_count;
    logic                  o_wrap;
    logic                  o_led;
    seg_t                  seg;
    logic [0:NUM_DIGITS-1] an;
    logic                  dp;

    updown_counter_seg #(
        .WIDTH      (WIDTH),
        .TICK_DIV   (TICK_DIV),
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_up         (i_up),
        .i_load       (i_load),
        .i_load_value (i_load_value),
        .o_count      (o_count),
        .o_wrap       (o_wrap),
        .o_led        (o_led),
        .seg          (seg),
        .an           (an),
        .dp           (dp)
    );

    // scoreboard: {kind, expected value}
    logic [19:0] exp_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;
    bit done         = 1'b0;

    task automatic push_exp(input logic [3:0] kind, input logic [15:0] val);
        exp_q.push_back({kind, val});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_count(input logic [7:0] c, input logic w);
        push_exp(K_COUNT, {8'h00, c});
        push_exp(K_WRAP, {15'h0, w});
        push_exp(K_LED, {15'h0, c[7]});
    endtask

    task automatic exp_reset_state();
        exp_count(8'h00, 1'b0);
        push_exp(K_SEG, {9'h0, 7'b1111111});
        push_exp(K_AN, {12'h0, 4'b1111});
        push_exp(K_DP, 16'h0001);
    endtask

    // Expected display slot: digit d lit with pattern s, or fully blanked.
    task automatic exp_digit(input int d, input logic [6:0] s, input bit blank);
        logic [0:3] a;
        a = 4'b1111;
        if (!blank) a[d] = 1'b0;
        push_exp(K_SEG, {9'h0, blank ? 7'b1111111 : s});
        push_exp(K_AN, {12'h0, a});
    endtask

    // monitor
    always @(negedge clk) begin : monitor
        logic [19:0] e;
        logic [15:0] got;
        string       name;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e[19:16])
                K_COUNT: begin got = {8'h00, o_count}; name = "count"; end
                K_WRAP:  begin got = {15'h0, o_wrap};  name = "wrap";  end
                K_LED:   begin got = {15'h0, o_led};   name = "led";   end
                K_SEG:   begin got = {9'h0, seg};      name = "seg";   end
                K_AN:    begin got = {12'h0, an};      name = "an";    end
                default: begin got = {15'h0, dp};      name = "dp";    end
            endcase
            n_compared++;
            if (got !== e[15:0]) begin
                n_mismatched++;
                $display("FAIL %s at %0t: got %h expected %h", name, $time, got, e[15:0]);
            end
        end
    end

    // directed vectors for the 8'h3C display scan
    logic [6:0] scan_seg_tab [0:3];
    bit         scan_blank_tab [0:3];

    initial begin
        scan_seg_tab[0] = 7'b0110001;  // C
        scan_seg_tab[1] = 7'b0000110;  // 3
        scan_seg_tab[2] = 7'b0000001;  // 0
        scan_seg_tab[3] = 7'b0000001;
        scan_blank_tab[0] = 1'b0;
        scan_blank_tab[1] = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        scan_blank_tab[2] = 1'b1;
        scan_blank_tab[3] = 1'b1;
`else
        scan_blank_tab[2] = 1'b0;
        scan_blank_tab[3] = 1'b0;
`endif

        i_reset      = 1'b1;
        i_enable     = 1'b0;
        i_up         = 1'b1;
        i_load       = 1'b0;
        i_load_value = '0;

        // reset held 3 cycles
        repeat (3) begin
            step();
            exp_reset_state();
        end

        // count up from release: one step per 4 cycles
        i_reset  = 1'b0;
        i_enable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 3)  exp_count(8'd0, 1'b0);
            if (n == 4)  exp_count(8'd1, 1'b0);
            if (n == 40) exp_count(8'd10, 1'b0);
        end
        i_enable = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            exp_count(8'd10, 1'b0);
        end

        // wrap up then wrap down
        i_load       = 1'b1;
        i_load_value = 8'hFF;
        step();
        exp_count(8'hFF, 1'b0);
        i_load   = 1'b0;
        i_enable = 1'b1;
        i_up     = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            exp_count(8'hFF, 1'b0);
        end
        step();
        exp_count(8'h00, 1'b1);
        step();
        exp_count(8'h00, 1'b0);
        i_up = 1'b0;
        step();
        exp_count(8'h00, 1'b0);
        step();
        exp_count(8'h00, 1'b0);
        step();
        exp_count(8'hFF, 1'b1);
        step();
        exp_count(8'hFF, 1'b0);

        // load in the tick cycle wins; next step 4 cycles later
        step();
        step();
        exp_count(8'hFF, 1'b0);
        i_load       = 1'b1;
        i_load_value = 8'h5A;
        step();
        exp_count(8'h5A, 1'b0);
        i_load = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            step();
            exp_count(8'h5A, 1'b0);
        end
        step();
        exp_count(8'h59, 1'b0);

        // display scan of 8'h3C from a fresh reset
        i_enable = 1'b0;
        i_reset  = 1'b1;
        step();
        exp_reset_state();
        i_reset      = 1'b0;
        i_load       = 1'b1;
        i_load_value = 8'h3C;
        step();
        exp_count(8'h3C, 1'b0);
        exp_digit(0, 7'b0000001, 1'b0);
        i_load = 1'b0;
        for (int k = 2; k <= 10; k++) begin
            step();
            exp_digit(((k - 1) / 2) % 4, scan_seg_tab[((k - 1) / 2) % 4],
                      scan_blank_tab[((k - 1) / 2) % 4]);
        end
        push_exp(K_DP, 16'h0001);

        // reset mid-prescale at 8'h37
        i_load       = 1'b1;
        i_load_value = 8'h37;
        i_enable     = 1'b1;
        i_up         = 1'b1;
        step();
        i_load = 1'b0;
        step();
        step();
        exp_count(8'h37, 1'b0);
        i_reset = 1'b1;
        step();
        exp_reset_state();
        i_reset = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            step();
            exp_count(8'h00, 1'b0);
        end
        step();
        exp_count(8'h01, 1'b0);

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // global time limit
    initial begin
        #20000;
        if (!done) begin
            n_mismatched++;
            $display("FAIL watchdog: got timeout expected completion");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
            $finish;
        end
    end

endmodule
